cu_issue_controller: RTL and testbench

//  Sequences one compute unit's instruction stream. Fetches 16-bit instructions from

---
 rtl/cu_isa_pkg.sv | 41 ++++
 rtl/cu_issue_hazard_check.sv | 29 ++
 rtl/cu_issue_controller.sv | 150 +++++++++++++++
 tb/tb_cu_issue_controller.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_isa_pkg.sv
// Shared ISA definitions for the compute-unit issue controller: widths,
// opcode values, instruction field positions and FSM state encoding.
package cu_isa_pkg;

   localparam int INST_WIDTH = 16;
   localparam int PC_WIDTH   = 8;
   localparam int NUM_ARRAYS = 4;
   localparam int NUM_WARPS  = 4;

   localparam logic [3:0] OP_SETMASK    = 4'h1;
   localparam logic [3:0] OP_SYNC       = 4'hE;
   localparam logic [3:0] OP_HALT       = 4'hF;
   localparam logic [3:0] OP_ARRAY_BASE = 4'h8;

   // Field slice positions inside a 16-bit instruction
   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int TGT_MSB  = 11;
   localparam int TGT_LSB  = 8;
   localparam int ADDR_MSB = 7;
   localparam int ADDR_LSB = 4;
   localparam int IMM_MSB  = 3;
   localparam int IMM_LSB  = 0;
   localparam int AID_MSB  = 3;
   localparam int AID_LSB  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_DECODE,
      ST_STALL,
      ST_ISSUE
   } cu_state_t;

   // Array ops occupy opcodes 8..B, i.e. the upper two opcode bits equal those of OP_ARRAY_BASE
   function automatic logic is_array_op(input logic [3:0] opc);
      return opc[3:2] == OP_ARRAY_BASE[3:2];
   endfunction

endpackage

// File: rtl/cu_issue_hazard_check.sv
// Combinational decode of the instruction register: classifies control
// opcodes and reports whether issue must stall on tensor-array busy.
module cu_issue_hazard_check
   import cu_isa_pkg::*;
(
   input  logic [INST_WIDTH-1:0] i_ir,
   input  logic [NUM_ARRAYS-1:0] i_array_busy,
   output logic                  o_is_halt,
   output logic                  o_is_sync,
   output logic                  o_is_setmask,
   output logic                  o_stall
);

   logic [3:0] w_opc;
   logic [1:0] w_aid;
   logic       w_array_hit;

   assign w_opc = i_ir[OPC_MSB:OPC_LSB];
   assign w_aid = i_ir[AID_MSB:AID_LSB];

   assign o_is_halt    = (w_opc == OP_HALT);
   assign o_is_sync    = (w_opc == OP_SYNC);
   assign o_is_setmask = (w_opc == OP_SETMASK);

   // Only the addressed array matters for an array op; SYNC waits for all of them
   assign w_array_hit = is_array_op(w_opc) & i_array_busy[w_aid];
   assign o_stall     = o_is_sync ? (|i_array_busy) : w_array_hit;

endmodule

// File: rtl/cu_issue_controller.sv
// Instruction sequencer for one compute unit: fetch by PC, decode, apply
// HALT/SYNC/SETMASK locally and hand everything else to the datapath
// over a valid/ready handshake, stalling while the target array is busy.
module cu_issue_controller
   import cu_isa_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [PC_WIDTH-1:0]   i_start_pc,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_pc_overflow,
   output logic                  o_imem_req,
   output logic [PC_WIDTH-1:0]   o_imem_addr,
   input  logic                  i_imem_valid,
   input  logic [INST_WIDTH-1:0] i_imem_data,
   input  logic [NUM_ARRAYS-1:0] i_array_busy,
   output logic                  o_issue_valid,
   input  logic                  i_issue_ready,
   output logic [INST_WIDTH-1:0] o_issue_inst,
   output logic [NUM_WARPS-1:0]  o_issue_mask
);

   cu_state_t             r_state;
   logic [PC_WIDTH-1:0]   r_pc;
   logic [INST_WIDTH-1:0] r_ir;
   logic [NUM_WARPS-1:0]  r_mask;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_overflow;
   logic                  r_imem_req;
   logic                  r_issue_valid;

   logic                  w_is_halt;
   logic                  w_is_sync;
   logic                  w_is_setmask;
   logic                  w_stall;
   logic [PC_WIDTH-1:0]   w_pc_inc;
   logic                  w_pc_wrap;

   cu_issue_hazard_check u_hazard (
      .i_ir         (r_ir),
      .i_array_busy (i_array_busy),
      .o_is_halt    (w_is_halt),
      .o_is_sync    (w_is_sync),
      .o_is_setmask (w_is_setmask),
      .o_stall      (w_stall)
   );

   assign w_pc_inc  = r_pc + 1'b1;
   assign w_pc_wrap = &r_pc;

   // Single FSM: sequences fetch/decode/issue and owns PC, IR, mask and all registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_pc          <= '0;
         r_ir          <= '0;
         r_mask        <= '1;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_overflow    <= 1'b0;
         r_imem_req    <= 1'b0;
         r_issue_valid <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_imem_req <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_pc       <= i_start_pc;
                  r_overflow <= 1'b0;
                  r_busy     <= 1'b1;
                  r_imem_req <= 1'b1;
                  r_state    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_imem_valid) begin
                  r_ir    <= i_imem_data;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (w_is_halt) begin
                  // PC is left pointing at the HALT
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_is_setmask) begin
                  r_mask     <= r_ir[IMM_MSB:IMM_LSB];
                  r_pc       <= w_pc_inc;
                  r_overflow <= r_overflow | w_pc_wrap;
                  r_imem_req <= 1'b1;
                  r_state    <= ST_FETCH;
               end else if (w_stall) begin
                  r_state <= ST_STALL;
               end else if (w_is_sync) begin
                  r_pc       <= w_pc_inc;
                  r_overflow <= r_overflow | w_pc_wrap;
                  r_imem_req <= 1'b1;
                  r_state    <= ST_FETCH;
               end else begin
                  r_issue_valid <= 1'b1;
                  r_state       <= ST_ISSUE;
               end
            end
            ST_STALL: begin
               if (!w_stall) begin
                  if (w_is_sync) begin
                     r_pc       <= w_pc_inc;
                     r_overflow <= r_overflow | w_pc_wrap;
                     r_imem_req <= 1'b1;
                     r_state    <= ST_FETCH;
                  end else begin
                     r_issue_valid <= 1'b1;
                     r_state       <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (i_issue_ready) begin
                  r_issue_valid <= 1'b0;
                  r_pc          <= w_pc_inc;
                  r_overflow    <= r_overflow | w_pc_wrap;
                  r_imem_req    <= 1'b1;
                  r_state       <= ST_FETCH;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_pc_overflow = r_overflow;
   assign o_imem_req    = r_imem_req;
   assign o_imem_addr   = r_pc;
   assign o_issue_valid = r_issue_valid;
   assign o_issue_inst  = r_ir;
   assign o_issue_mask  = r_mask;

endmodule

// File: tb/tb_cu_issue_controller.sv
// Self-checking bench for cu_issue_controller: table of short programs with
// hand-derived results, directed multi-cycle corner cases, and random
// programs checked against an instruction-level reference model.
module tb_cu_issue_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  start_pc = 8'h00;
   logic        busy;
   logic        done;
   logic        pc_overflow;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_valid = 1'b0;
   logic [15:0] imem_data = 16'h0000;
   logic [3:0]  array_busy = 4'h0;
   logic        issue_valid;
   logic        issue_ready = 1'b1;
   logic [15:0] issue_inst;
   logic [3:0]  issue_mask;

   cu_issue_controller dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_start_pc    (start_pc),
      .o_busy        (busy),
      .o_done        (done),
      .o_pc_overflow (pc_overflow),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_valid  (imem_valid),
      .i_imem_data   (imem_data),
      .i_array_busy  (array_busy),
      .o_issue_valid (issue_valid),
      .i_issue_ready (issue_ready),
      .o_issue_inst  (issue_inst),
      .o_issue_mask  (issue_mask)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] inst;
      logic [3:0]  mask;
   } iss_t;

   typedef struct {
      logic [7:0]  spc;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [15:0] w2;
      logic [3:0]  bval;
      int          bcyc;
      int          exp_issues;
      logic [15:0] exp_inst;
      logic [3:0]  exp_mask;
      int          exp_fetch;
      logic        exp_ovf;
   } vec_t;

   logic [15:0] mem [256];
   int          n_vec = 0;
   int          n_err = 0;
   int          imem_lat = 0;
   bit          rand_mode = 1'b0;
   int          done_cnt = 0;

   iss_t        obs_q[$];
   logic [7:0]  fetch_q[$];
   iss_t        exp_iss[$];
   logic [7:0]  exp_fetch[$];
   logic        exp_ovf;
   logic [3:0]  model_mask = 4'hF;

   bit          last_valid = 1'b0;
   logic [15:0] last_inst = 16'h0;
   logic [3:0]  last_mask = 4'h0;
   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic [7:0]  pend_addr = 8'h0;

   vec_t        tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // One clock: observe outputs just after the edge, then play imem and (optionally) random inputs
   task automatic step();
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (last_valid && !issue_ready)
            check("hold_stable", 32'({issue_valid, issue_inst, issue_mask}),
                  32'({1'b1, last_inst, last_mask}));
         if (last_valid && issue_ready)
            obs_q.push_back('{inst: last_inst, mask: last_mask});
      end
      if (done) done_cnt++;
      last_valid = issue_valid && rst_n;
      last_inst  = issue_inst;
      last_mask  = issue_mask;
      imem_valid = 1'b0;
      if (pend) begin
         if (pend_cnt == 0) begin
            imem_valid = 1'b1;
            imem_data  = mem[pend_addr];
            pend       = 1'b0;
         end else begin
            pend_cnt--;
         end
      end
      if (imem_req) begin
         pend      = 1'b1;
         pend_cnt  = imem_lat;
         pend_addr = imem_addr;
         fetch_q.push_back(imem_addr);
      end
      if (rand_mode) begin
         issue_ready = ($urandom_range(0, 2) != 0);
         array_busy  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      end
   endtask

   task automatic run_prog(input logic [7:0] spc, input logic [3:0] bval, input int bcyc, input int maxc);
      obs_q.delete();
      fetch_q.delete();
      done_cnt = 0;
      if (!rand_mode) begin
         array_busy  = bval;
         issue_ready = 1'b1;
      end
      start    = 1'b1;
      start_pc = spc;
      step();
      start = 1'b0;
      for (int c = 0; c < maxc && done_cnt == 0; c++) begin
         if (!rand_mode && c == bcyc) array_busy = 4'h0;
         step();
      end
      step();
      step();
      check("run_done_once", 32'(done_cnt), 32'd1);
      check("run_busy_low", 32'(busy), 32'd0);
      if (rand_mode) begin
         issue_ready = 1'b1;
         array_busy  = 4'h0;
      end
   endtask

   // Instruction-level reference: walk the program, no timing involved
   task automatic model_run(input logic [7:0] spc);
      logic [7:0]  pc;
      logic [15:0] w;
      exp_iss.delete();
      exp_fetch.delete();
      exp_ovf = 1'b0;
      pc = spc;
      for (int k = 0; k < 300; k++) begin
         exp_fetch.push_back(pc);
         w = mem[pc];
         if (w[15:12] == 4'hF) break;
         if (w[15:12] == 4'h1) model_mask = w[3:0];
         else if (w[15:12] != 4'hE) exp_iss.push_back('{inst: w, mask: model_mask});
         if (pc == 8'hFF) exp_ovf = 1'b1;
         pc = pc + 8'd1;
      end
   endtask

   task automatic wait_done(input string name);
      for (int c = 0; c < 60 && done_cnt == 0; c++) step();
      check(name, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      int          cnt;
      logic [7:0]  a;
      logic [15:0] w;
      int          len;

      foreach (mem[i]) mem[i] = 16'hF000;

      tbl[0] = '{8'h10, 16'h2ABC, 16'hF000, 16'h0000, 4'h0, 0, 1, 16'h2ABC, 4'hF, 2, 1'b0};
      tbl[1] = '{8'h20, 16'h1005, 16'h3123, 16'hF000, 4'h0, 0, 1, 16'h3123, 4'h5, 3, 1'b0};
      tbl[2] = '{8'h30, 16'h8008, 16'hF000, 16'h0000, 4'b0100, 5, 1, 16'h8008, 4'h5, 2, 1'b0};
      tbl[3] = '{8'h40, 16'hE000, 16'h4444, 16'hF000, 4'b1001, 6, 1, 16'h4444, 4'h5, 3, 1'b0};
      tbl[4] = '{8'hFF, 16'h7777, 16'hF000, 16'h0000, 4'h0, 0, 1, 16'h7777, 4'h5, 2, 1'b1};
      tbl[5] = '{8'hFF, 16'h100F, 16'h5555, 16'hF000, 4'h0, 0, 1, 16'h5555, 4'hF, 3, 1'b1};
      tbl[6] = '{8'h50, 16'h1000, 16'h9004, 16'hF000, 4'b0001, 8, 1, 16'h9004, 4'h0, 3, 1'b0};
      tbl[7] = '{8'h60, 16'h100F, 16'hF000, 16'h0000, 4'h0, 0, 0, 16'h0000, 4'hF, 2, 1'b0};
      tbl[8] = '{8'h68, 16'hA00C, 16'hF000, 16'h0000, 4'b1000, 4, 1, 16'hA00C, 4'hF, 2, 1'b0};

      // Reset state
      repeat (3) step();
      check("reset_outputs",
            32'({busy, done, pc_overflow, imem_req, imem_addr, issue_valid, issue_mask}),
            32'({1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'hF}));
      check("reset_inst", 32'(issue_inst), 32'h0);
      rst_n = 1'b1;
      step();

      // Table of short programs with hand-derived expectations
      for (int i = 0; i < 9; i++) begin
         a = tbl[i].spc;
         mem[a] = tbl[i].w0;
         a = a + 8'd1;
         mem[a] = tbl[i].w1;
         a = a + 8'd1;
         mem[a] = tbl[i].w2;
         imem_lat = 0;
         run_prog(tbl[i].spc, tbl[i].bval, tbl[i].bcyc, 200);
         $display("vector %0d: start_pc=%h issues=%0d fetches=%0d ovf=%b", i, tbl[i].spc,
                  obs_q.size(), fetch_q.size(), pc_overflow);
         check("tbl_issue_count", 32'(obs_q.size()), 32'(tbl[i].exp_issues));
         if (tbl[i].exp_issues > 0) begin
            if (obs_q.size() > 0)
               check("tbl_issue", 32'({obs_q[0].inst, obs_q[0].mask}),
                     32'({tbl[i].exp_inst, tbl[i].exp_mask}));
         end
         check("tbl_fetch_count", 32'(fetch_q.size()), 32'(tbl[i].exp_fetch));
         if (fetch_q.size() > 0) check("tbl_first_fetch", 32'(fetch_q[0]), 32'(tbl[i].spc));
         check("tbl_overflow", 32'(pc_overflow), 32'(tbl[i].exp_ovf));
      end

      // Array op stalls while its array is busy, issues the cycle after it clears
      mem[8'h70] = 16'h8008;
      mem[8'h71] = 16'hF000;
      obs_q.delete(); fetch_q.delete(); done_cnt = 0;
      array_busy = 4'b0100; issue_ready = 1'b1;
      start = 1'b1; start_pc = 8'h70; step(); start = 1'b0;
      cnt = 0;
      repeat (10) begin step(); if (issue_valid) cnt++; end
      check("arr_stall_no_issue", 32'(cnt), 32'd0);
      array_busy = 4'h0;
      step();
      check("arr_issue_after_clear", 32'({issue_valid, issue_inst}), 32'({1'b1, 16'h8008}));
      wait_done("arr_done");
      $display("seq array_stall: issues=%0d", obs_q.size());

      // Back-pressure: issue held stable, PC frozen until handshake
      mem[8'h80] = 16'h6789;
      mem[8'h81] = 16'hF000;
      obs_q.delete(); fetch_q.delete(); done_cnt = 0;
      issue_ready = 1'b0;
      start = 1'b1; start_pc = 8'h80; step(); start = 1'b0;
      for (int c = 0; c < 20 && !issue_valid; c++) step();
      check("bp_valid_seen", 32'(issue_valid), 32'd1);
      repeat (3) begin
         step();
         check("bp_hold", 32'({issue_valid, issue_inst, issue_mask, imem_req, imem_addr}),
               32'({1'b1, 16'h6789, 4'hF, 1'b0, 8'h80}));
      end
      issue_ready = 1'b1;
      step();
      check("bp_after_xfer", 32'({issue_valid, imem_req, imem_addr}), 32'({1'b0, 1'b1, 8'h81}));
      wait_done("bp_done");
      $display("seq backpressure: issues=%0d", obs_q.size());

      // SYNC: no fetch until every array is idle
      mem[8'h90] = 16'hE000;
      mem[8'h91] = 16'hF000;
      obs_q.delete(); fetch_q.delete(); done_cnt = 0;
      array_busy = 4'b1001;
      start = 1'b1; start_pc = 8'h90; step(); start = 1'b0;
      cnt = 0;
      repeat (8) begin step(); if (imem_req) cnt++; end
      array_busy = 4'b1000;
      repeat (3) begin step(); if (imem_req) cnt++; end
      check("sync_no_fetch", 32'(cnt), 32'd0);
      array_busy = 4'h0;
      step();
      check("sync_fetch_after_clear", 32'({imem_req, imem_addr}), 32'({1'b1, 8'h91}));
      wait_done("sync_done");
      $display("seq sync: fetches=%0d", fetch_q.size());

      // Random programs against the reference model
      model_mask = 4'hF;
      rand_mode = 1'b1;
      for (int n = 0; n < 40; n++) begin
         len = $urandom_range(1, 10);
         a = ($urandom_range(0, 3) == 0) ? 8'(8'hFF - len / 2) : 8'($urandom);
         start_pc = a;
         for (int k = 0; k < len; k++) begin
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(0, 14));
            mem[a] = w;
            a = a + 8'd1;
         end
         mem[a] = 16'hF000 | 16'($urandom_range(0, 4095));
         imem_lat = $urandom_range(0, 2);
         model_run(start_pc);
         run_prog(start_pc, 4'h0, 0, 3000);
         $display("random %0d: start_pc=%h len=%0d issues=%0d/%0d fetches=%0d/%0d ovf=%b", n,
                  start_pc, len, obs_q.size(), exp_iss.size(), fetch_q.size(), exp_fetch.size(),
                  pc_overflow);
         check("rnd_issue_count", 32'(obs_q.size()), 32'(exp_iss.size()));
         for (int k = 0; k < exp_iss.size() && k < obs_q.size(); k++)
            check("rnd_issue", 32'(obs_q[k]), 32'(exp_iss[k]));
         check("rnd_fetch_count", 32'(fetch_q.size()), 32'(exp_fetch.size()));
         for (int k = 0; k < exp_fetch.size() && k < fetch_q.size(); k++)
            check("rnd_fetch_addr", 32'(fetch_q[k]), 32'(exp_fetch[k]));
         check("rnd_overflow", 32'(pc_overflow), 32'(exp_ovf));
      end
      rand_mode = 1'b0;
      issue_ready = 1'b1;
      array_busy = 4'h0;

      // Reset in the middle of a fetch wait; the late imem_valid must be ignored
      mem[8'hA0] = 16'h1003;
      mem[8'hA1] = 16'h2000;
      mem[8'hA2] = 16'hF000;
      imem_lat = 3;
      obs_q.delete(); fetch_q.delete(); done_cnt = 0;
      start = 1'b1; start_pc = 8'hA0; step(); start = 1'b0;
      for (int c = 0; c < 40 && !(imem_req && imem_addr == 8'hA1); c++) step();
      check("rst_pre_mask", 32'({imem_req, issue_mask}), 32'({1'b1, 4'h3}));
      step();
      rst_n = 1'b0;
      #1;
      check("rst_mid_outputs",
            32'({busy, done, pc_overflow, imem_req, imem_addr, issue_valid, issue_mask}),
            32'({1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'hF}));
      step();
      rst_n = 1'b1;
      cnt = 0;
      repeat (8) begin
         step();
         if (busy || imem_req || issue_valid || done || imem_addr != 8'h00) cnt++;
      end
      check("rst_stray_ignored", 32'(cnt), 32'd0);
      check("rst_final_mask", 32'({issue_mask, issue_inst}), 32'({4'hF, 16'h0000}));
      $display("seq reset_mid_wait: issues=%0d", obs_q.size());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
